// File: rtl/aes_pkg.sv
// Shared AES definitions: round counts, round-index width and the inverse
// round-controller state encoding.
package aes_pkg;

    localparam int AES128_NR = 10;
    localparam int RND_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        INIT,
        ROUND,
        LAST,
        DONE
    } inv_cntx_state_t;

endpackage

// File: rtl/aes_inv_cntx.sv
// Round controller for the AES inverse cipher: forward key expansion, initial
// AddRoundKey, NR-1 inverse rounds and a final round without InvMixColumns.
module aes_inv_cntx
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    output logic             accept,
    output logic [RND_W-1:0] rndNo,
    output logic             enbKS,
    output logic             enbIKS,
    output logic             enbISR,
    output logic             enbISB,
    output logic             enbIMC,
    output logic             enbAR,
    output logic             done,
    output logic [NR-1:0]    completed_round
);

    localparam logic [RND_W-1:0] NR_R     = RND_W'(NR);
    localparam logic [RND_W-1:0] LAST_IDX = RND_W'(NR - 1);
    localparam logic [RND_W-1:0] RND_ONE  = RND_W'(1);
    localparam logic [NR-1:0]    CR_ONE   = NR'(1);

    inv_cntx_state_t  state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    assign rndNo = rnd_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_d         = state_q;
        rnd_d           = rnd_q;
        accept          = 1'b0;
        enbKS           = 1'b0;
        enbIKS          = 1'b0;
        enbISR          = 1'b0;
        enbISB          = 1'b0;
        enbIMC          = 1'b0;
        enbAR           = 1'b0;
        done            = 1'b0;
        completed_round = '0;

        case (state_q)
            IDLE: begin
                accept = 1'b1;
                rnd_d  = '0;
                if (start) begin
                    state_d = KEYEXP;
                    rnd_d   = RND_ONE;
                end
            end

            KEYEXP: begin
                enbKS = 1'b1;
                if (rnd_q == NR_R) begin
                    state_d = INIT;
                end else begin
                    rnd_d = rnd_q + RND_ONE;
                end
            end

            // Whitening with the last round key while stepping the key back one round.
            INIT: begin
                enbAR   = 1'b1;
                enbIKS  = 1'b1;
                state_d = ROUND;
                rnd_d   = NR_R - RND_ONE;
            end

            ROUND: begin
                enbISR          = 1'b1;
                enbISB          = 1'b1;
                enbAR           = 1'b1;
                enbIMC          = 1'b1;
                enbIKS          = 1'b1;
                completed_round = CR_ONE << (LAST_IDX - rnd_q);
                if (rnd_q == RND_ONE) begin
                    state_d = LAST;
                    rnd_d   = '0;
                end else begin
                    rnd_d = rnd_q - RND_ONE;
                end
            end

            LAST: begin
                enbISR          = 1'b1;
                enbISB          = 1'b1;
                enbAR           = 1'b1;
                completed_round = CR_ONE << LAST_IDX;
                state_d         = DONE;
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                rnd_d   = '0;
            end

            default: begin
                state_d = IDLE;
                rnd_d   = '0;
            end
        endcase
    end

endmodule
